ma_crossover_filter: RTL and testbench

Parametrised dual-window moving-average engine for the trading datapath. It accepts a stream of unsigned price samples, keeps a shared circular history buffer, and produces a fast (short-window) and a slow (long-window) simple moving average every accepted sample. It also emits one-cycle crossover pulses when the fast average crosses the slow one. It sits between the GPIO sample capture and the trade-decision logic, and generalises the fixed 8-bit/32-tap averager to configurable width and windows, with valid qualification, flush and signal generation.

---
 rtl/ma_crossover_filter.sv | 187 ++++++++++++++++++
 tb/tb_ma_crossover_filter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ma_crossover_filter.sv
// Dual-window (fast/slow) moving-average engine over a shared circular history,
// with crossover pulses. Define MA_ROUND_EN to round averages half-up instead of truncating.
module ma_crossover_filter #(
    parameter int DATA_W    = 8,
    parameter int FAST_LOG2 = 2,
    parameter int SLOW_LOG2 = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    output logic              out_valid,
    output logic [DATA_W-1:0] fast_avg,
    output logic [DATA_W-1:0] slow_avg,
    output logic              primed,
    output logic              cross_up,
    output logic              cross_down
);

    localparam int DEPTH  = 1 << SLOW_LOG2;
    localparam int FAST_N = 1 << FAST_LOG2;
    localparam int FW     = DATA_W + FAST_LOG2;
    localparam int SW     = DATA_W + SLOW_LOG2;

    localparam logic [SLOW_LOG2:0]   FILL_FULL = (SLOW_LOG2+1)'(DEPTH);
    localparam logic [SLOW_LOG2:0]   FILL_FAST = (SLOW_LOG2+1)'(FAST_N);
    localparam logic [SLOW_LOG2:0]   FILL_ONE  = (SLOW_LOG2+1)'(1);
    localparam logic [SLOW_LOG2-1:0] FAST_OFF  = SLOW_LOG2'(FAST_N);
    localparam logic [SLOW_LOG2-1:0] WPTR_ONE  = SLOW_LOG2'(1);

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_BELOW  = 2'd1,
        ST_ABOVE  = 2'd2
    } xover_state_t;

    logic [DATA_W-1:0]    r_buf [DEPTH];
    logic [SLOW_LOG2-1:0] r_wptr;
    logic [SLOW_LOG2:0]   r_fill;
    logic [FW-1:0]        r_fast_sum;
    logic [SW-1:0]        r_slow_sum;
    xover_state_t         r_state;

    logic                 w_accept;
    logic [SLOW_LOG2-1:0] w_fast_addr;
    logic [DATA_W-1:0]    w_slow_old;
    logic [DATA_W-1:0]    w_fast_old;
    logic [FW-1:0]        w_fast_sum_nxt;
    logic [SW-1:0]        w_slow_sum_nxt;
    logic [SLOW_LOG2:0]   w_fill_nxt;
    logic                 w_primed_nxt;
    logic [DATA_W-1:0]    w_fast_avg;
    logic [DATA_W-1:0]    w_slow_avg;
    logic                 w_above;

    assign w_accept = in_valid & ~clear;

    // Samples leaving each window; entries not yet written since clear read as zero.
    always_comb begin
        w_fast_addr = r_wptr - FAST_OFF;
        if (r_fill == FILL_FULL) begin
            w_slow_old = r_buf[r_wptr];
        end else begin
            w_slow_old = {DATA_W{1'b0}};
        end
        if (r_fill >= FILL_FAST) begin
            w_fast_old = r_buf[w_fast_addr];
        end else begin
            w_fast_old = {DATA_W{1'b0}};
        end
    end

    // Running sums and saturating fill count for the sample being accepted.
    always_comb begin
        w_fast_sum_nxt = r_fast_sum + FW'(in_data) - FW'(w_fast_old);
        w_slow_sum_nxt = r_slow_sum + SW'(in_data) - SW'(w_slow_old);
        if (r_fill == FILL_FULL) begin
            w_fill_nxt = r_fill;
        end else begin
            w_fill_nxt = r_fill + FILL_ONE;
        end
        w_primed_nxt = (w_fill_nxt == FILL_FULL);
    end

`ifdef MA_ROUND_EN
    localparam logic [FW:0] FAST_HALF = (FW+1)'(FAST_N / 2);
    localparam logic [SW:0] SLOW_HALF = (SW+1)'(DEPTH / 2);

    logic [FW:0] w_fast_rnd;
    logic [SW:0] w_slow_rnd;

    // Round half up; the clamp never engages for in-range sums but keeps the top bit meaningful.
    always_comb begin
        w_fast_rnd = {1'b0, w_fast_sum_nxt} + FAST_HALF;
        w_slow_rnd = {1'b0, w_slow_sum_nxt} + SLOW_HALF;
        if (w_fast_rnd[FW]) begin
            w_fast_avg = {DATA_W{1'b1}};
        end else begin
            w_fast_avg = w_fast_rnd[FW-1:FAST_LOG2];
        end
        if (w_slow_rnd[SW]) begin
            w_slow_avg = {DATA_W{1'b1}};
        end else begin
            w_slow_avg = w_slow_rnd[SW-1:SLOW_LOG2];
        end
    end
`else
    // Truncating division by the full window length.
    always_comb begin
        w_fast_avg = w_fast_sum_nxt[FW-1:FAST_LOG2];
        w_slow_avg = w_slow_sum_nxt[SW-1:SLOW_LOG2];
    end
`endif

    assign w_above = (w_fast_avg > w_slow_avg);

    // History storage; contents are deliberately left unreset, the fill count masks them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wptr] <= in_data;
        end
    end

    // Filter state, registered outputs and crossover FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= {SLOW_LOG2{1'b0}};
            r_fill     <= {(SLOW_LOG2+1){1'b0}};
            r_fast_sum <= {FW{1'b0}};
            r_slow_sum <= {SW{1'b0}};
            r_state    <= ST_WARMUP;
            out_valid  <= 1'b0;
            fast_avg   <= {DATA_W{1'b0}};
            slow_avg   <= {DATA_W{1'b0}};
            primed     <= 1'b0;
            cross_up   <= 1'b0;
            cross_down <= 1'b0;
        end else if (clear) begin
            r_wptr     <= {SLOW_LOG2{1'b0}};
            r_fill     <= {(SLOW_LOG2+1){1'b0}};
            r_fast_sum <= {FW{1'b0}};
            r_slow_sum <= {SW{1'b0}};
            r_state    <= ST_WARMUP;
            out_valid  <= 1'b0;
            fast_avg   <= {DATA_W{1'b0}};
            slow_avg   <= {DATA_W{1'b0}};
            primed     <= 1'b0;
            cross_up   <= 1'b0;
            cross_down <= 1'b0;
        end else if (in_valid) begin
            r_wptr     <= r_wptr + WPTR_ONE;
            r_fill     <= w_fill_nxt;
            r_fast_sum <= w_fast_sum_nxt;
            r_slow_sum <= w_slow_sum_nxt;
            out_valid  <= 1'b1;
            fast_avg   <= w_fast_avg;
            slow_avg   <= w_slow_avg;
            primed     <= w_primed_nxt;
            cross_up   <= 1'b0;
            cross_down <= 1'b0;
            if (w_primed_nxt) begin
                case (r_state)
                    ST_WARMUP: r_state <= w_above ? ST_ABOVE : ST_BELOW;
                    ST_BELOW: begin
                        if (w_above) begin
                            r_state  <= ST_ABOVE;
                            cross_up <= 1'b1;
                        end
                    end
                    ST_ABOVE: begin
                        if (!w_above) begin
                            r_state    <= ST_BELOW;
                            cross_down <= 1'b1;
                        end
                    end
                    default: r_state <= ST_WARMUP;
                endcase
            end
        end else begin
            out_valid  <= 1'b0;
            cross_up   <= 1'b0;
            cross_down <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ma_crossover_filter.sv
// Self-checking bench for ma_crossover_filter: directed steps plus random samples
// compared against a queue-based moving-average reference.
module tb_ma_crossover_filter;

    localparam int DATA_W    = 8;
    localparam int FAST_LOG2 = 2;
    localparam int SLOW_LOG2 = 5;
    localparam int SLOW_N    = 1 << SLOW_LOG2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              clear;
    logic              out_valid;
    logic [DATA_W-1:0] fast_avg;
    logic [DATA_W-1:0] slow_avg;
    logic              primed;
    logic              cross_up;
    logic              cross_down;

    ma_crossover_filter #(
        .DATA_W   (DATA_W),
        .FAST_LOG2(FAST_LOG2),
        .SLOW_LOG2(SLOW_LOG2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear     (clear),
        .out_valid (out_valid),
        .fast_avg  (fast_avg),
        .slow_avg  (slow_avg),
        .primed    (primed),
        .cross_up  (cross_up),
        .cross_down(cross_down)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: the samples since the last clear, newest at the back.
    int          hist[$];
    int          seen;
    bit          have_side;
    bit          side_above;
    logic [31:0] m_ov, m_fast, m_slow, m_primed, m_up, m_dn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int window_avg(input int log2n);
        int n;
        int sum;
        n   = 1 << log2n;
        sum = 0;
        for (int k = 0; k < n && k < hist.size(); k++) sum += hist[hist.size() - 1 - k];
`ifdef MA_ROUND_EN
        return (sum + n / 2) / n;
`else
        return sum / n;
`endif
    endfunction

    task automatic model_reset();
        hist.delete();
        seen = 0; have_side = 0; side_above = 0;
        m_ov = 0; m_fast = 0; m_slow = 0; m_primed = 0; m_up = 0; m_dn = 0;
    endtask

    task automatic model_accept(input int d);
        bit now_above;
        hist.push_back(d);
        if (hist.size() > SLOW_N) void'(hist.pop_front());
        seen++;
        m_ov = 1; m_up = 0; m_dn = 0;
        m_fast = window_avg(FAST_LOG2);
        m_slow = window_avg(SLOW_LOG2);
        m_primed = (seen >= SLOW_N) ? 1 : 0;
        if (seen >= SLOW_N) begin
            now_above = (m_fast > m_slow);
            if (have_side) begin
                m_up = (now_above && !side_above) ? 1 : 0;
                m_dn = (!now_above && side_above) ? 1 : 0;
            end
            have_side  = 1;
            side_above = now_above;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"},  32'(out_valid),  m_ov);
        check({tag, ".fast_avg"},   32'(fast_avg),   m_fast);
        check({tag, ".slow_avg"},   32'(slow_avg),   m_slow);
        check({tag, ".primed"},     32'(primed),     m_primed);
        check({tag, ".cross_up"},   32'(cross_up),   m_up);
        check({tag, ".cross_down"}, 32'(cross_down), m_dn);
    endtask

    // One clock of stimulus; outputs are compared 1 ns after the active edge.
    task automatic step(input bit v, input int d, input bit c, input string tag);
        @(negedge clk);
        in_valid = v;
        in_data  = DATA_W'(d);
        clear    = c;
        if (c) model_reset();
        else if (v) model_accept(d);
        else begin
            m_ov = 0; m_up = 0; m_dn = 0;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("por");
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 50, 1'b0, "first50");
`ifdef MA_ROUND_EN
        check("first50.fast_const", 32'(fast_avg), 32'd13);
        check("first50.slow_const", 32'(slow_avg), 32'd2);
`else
        check("first50.fast_const", 32'(fast_avg), 32'd12);
        check("first50.slow_const", 32'(slow_avg), 32'd1);
`endif
        do_reset();

        for (int i = 0; i < SLOW_N; i++) begin
            step(1'b1, 100, 1'b0, "const100");
            if (i < 4) check("const100.fast_ramp", 32'(fast_avg), 32'(25 * (i + 1)));
            if (i == 0) check("const100.slow_first", 32'(slow_avg), 32'd3);
            if (i == SLOW_N - 2) check("const100.not_primed", 32'(primed), 32'd0);
        end
        check("const100.slow_last", 32'(slow_avg), 32'd100);
        check("const100.primed", 32'(primed), 32'd1);
        check("const100.no_pulse", 32'(cross_up | cross_down), 32'd0);

        step(1'b1, 200, 1'b0, "spike200");
        check("spike200.fast", 32'(fast_avg), 32'd125);
        check("spike200.slow", 32'(slow_avg), 32'd103);
        check("spike200.up",   32'(cross_up), 32'd1);
        step(1'b1, 0, 1'b0, "drop0");
        check("drop0.fast", 32'(fast_avg), 32'd100);
        check("drop0.slow", 32'(slow_avg), 32'd100);
        check("drop0.down", 32'(cross_down), 32'd1);
        step(1'b0, 0, 1'b0, "after_pulse");
        check("after_pulse.down", 32'(cross_down), 32'd0);

        step(1'b1, 77, 1'b1, "clear77");
        check("clear77.fast",   32'(fast_avg), 32'd0);
        check("clear77.primed", 32'(primed),   32'd0);
        step(1'b1, 40, 1'b0, "after_clear40");
        check("after_clear40.fast", 32'(fast_avg), 32'd10);
        check("after_clear40.slow", 32'(slow_avg), 32'd1);

        for (int i = 0; i < 40; i++) begin
            step(1'b1, int'($urandom_range(0, 255)), 1'b0, "gap_sample");
            repeat (3) step(1'b0, int'($urandom_range(0, 255)), 1'b0, "gap_idle");
        end

        step(1'b0, 0, 1'b1, "clear_idle");
        for (int i = 0; i < 100; i++) begin
            step(1'b1, int'($urandom_range(0, 255)), 1'b0, "random");
        end

        @(negedge clk);
        in_valid = 1'b1; in_data = 8'd9; clear = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        step(1'b1, 60, 1'b0, "post_reset60");
        check("post_reset60.fast", 32'(fast_avg), 32'd15);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, int'($urandom_range(0, 255)), ($urandom_range(0, 29) == 0), "random_clr");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
